// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RV32I fetch stage: PC, single-outstanding imem request, one-word decode buffer.
// Define FETCH_MISALIGN_CHECK_EN to halt with a sticky misalign_fault on misaligned redirects.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        misalign_fault
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, OUT, DRAIN, HALT} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        fault_q, fault_d;
  logic [31:0] redir_pc;
  logic        redir_misaligned;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign redir_pc         = redirect_target;
  assign redir_misaligned = redirect_target[1:0] != 2'b00;
`else
  assign redir_pc         = redirect_target & 32'hFFFF_FFFC;
  assign redir_misaligned = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    fault_d    = fault_q;

    case (state_q)
      IDLE:  state_d = REQ;
      REQ:   if (imem_req_ready) state_d = WAIT;
      WAIT: begin
        if (imem_rsp_valid) begin
          instr_d    = imem_rsp_data;
          instr_pc_d = pc_q;
          pc_d       = pc_q + 32'd4;
          state_d    = OUT;
        end
      end
      OUT:   if (instr_ready) state_d = REQ;
      DRAIN: if (imem_rsp_valid) state_d = REQ;
      HALT:  state_d = HALT;
      default: state_d = IDLE;
    endcase

    // Redirect overrides everything above; a response landing this cycle is wrong-path.
    if (redirect_valid && state_q != HALT) begin
      pc_d       = redir_pc;
      instr_d    = instr_q;
      instr_pc_d = instr_pc_q;
      if (redir_misaligned) begin
        fault_d = 1'b1;
        state_d = HALT;
      end else begin
        case (state_q)
          REQ:     state_d = imem_req_ready ? DRAIN : REQ;
          WAIT:    state_d = imem_rsp_valid ? REQ : DRAIN;
          DRAIN:   state_d = imem_rsp_valid ? REQ : DRAIN;
          default: state_d = REQ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      instr_q    <= 32'h0;
      instr_pc_q <= 32'h0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      fault_q    <= fault_d;
    end
  end

  // A response is only legal while one is owed; HALT may still see a dropped one.
  always_ff @(posedge clk) begin
    if (!rst && imem_rsp_valid) begin
      assert (state_q == WAIT || state_q == DRAIN || state_q == HALT);
    end
  end

  assign imem_req_valid = (state_q == REQ);
  assign imem_addr      = pc_q;
  assign instr_valid    = (state_q == OUT);
  assign instr          = instr_q;
  assign instr_pc       = instr_pc_q;
  assign misalign_fault = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed + random bench for fetch_unit with a transaction-level scoreboard.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] K        = 32'hA5A5_A5A5;
  localparam logic [31:0] BP_ADDR  = 32'h0000_0200;

  logic        clk = 1'b0;
  logic        rst, redirect_valid, imem_req_ready, imem_rsp_valid, instr_ready;
  logic [31:0] redirect_target, imem_rsp_data;
  logic        imem_req_valid, instr_valid, misalign_fault;
  logic [31:0] imem_addr, instr, instr_pc;

  int total = 0;
  int bad   = 0;
  int ncons = 0;
  int cyc_n = 0;

  // Scoreboard: pc of the next instruction decode should see, and the memory's view.
  bit          pending   = 0;
  logic [31:0] pend_addr = 32'h0;
  logic [31:0] exp_pc    = RESET_PC;
  bit          redir_prev = 0;
  logic [31:0] redir_tgt  = 32'h0;
  bit          halted     = 0;

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .misalign_fault (misalign_fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == BP_ADDR) ? 32'h0000_0013 : (a ^ K);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: entered and left at posedge+1, inputs driven and outputs checked there.
  task automatic cyc(input bit r, input bit rr, input bit re, input bit rv,
                     input logic [31:0] rt, input bit ir);
    logic [31:0] tgt;
    rst             = r;
    imem_req_ready  = rr;
    redirect_valid  = rv;
    redirect_target = rt;
    instr_ready     = ir;
    imem_rsp_valid  = !r && re && pending;
    imem_rsp_data   = imem_rsp_valid ? mem_word(pend_addr) : $urandom;
    if (r) begin
      pending    = 0;
      exp_pc     = RESET_PC;
      redir_prev = 0;
      halted     = 0;
    end else if (halted) begin
      chk("halt_fault", misalign_fault, 1);
      chk("halt_noreq", imem_req_valid, 0);
      chk("halt_noinstr", instr_valid, 0);
      if (imem_rsp_valid) pending = 0;
    end else begin
      chk("no_fault", misalign_fault, 0);
      if (redir_prev) begin
        chk("redir_ivalid", instr_valid, 0);
        if (!pending) begin
          chk("redir_req", imem_req_valid, 1);
          chk("redir_addr", imem_addr, redir_tgt);
        end else begin
          chk("redir_drain", imem_req_valid, 0);
        end
      end
      if (imem_req_valid) begin
        chk("one_outstanding", pending, 0);
        chk("req_addr", imem_addr, exp_pc);
      end
      if (instr_valid && ir) begin
        chk("instr_pc", instr_pc, exp_pc);
        chk("instr_word", instr, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
        ncons++;
      end
      tgt = rt;
`ifndef FETCH_MISALIGN_CHECK_EN
      tgt[1:0] = 2'b00;
`endif
      if (rv) begin
        exp_pc = tgt;
`ifdef FETCH_MISALIGN_CHECK_EN
        if (rt[1:0] != 2'b00) halted = 1;
`endif
      end
      redir_prev = rv;
      redir_tgt  = tgt;
      if (imem_rsp_valid) pending = 0;
      if (imem_req_valid && rr) begin
        pending   = 1;
        pend_addr = imem_addr;
      end
    end
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  initial begin
    int last_c;
    int c0;
    logic [31:0] t;
    rst = 1'b1; redirect_valid = 1'b0; redirect_target = 32'h0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0; instr_ready = 1'b0;

    // Reset for three cycles
    repeat (3) begin
      cyc(1, 1, 0, 0, 32'h0, 1);
      chk("rst_req", imem_req_valid, 0);
      chk("rst_ivalid", instr_valid, 0);
      chk("rst_instr", instr, 32'h0);
      chk("rst_ipc", instr_pc, 32'h0);
      chk("rst_fault", misalign_fault, 0);
      chk("rst_addr", imem_addr, RESET_PC);
    end
    cyc(0, 1, 1, 0, 32'h0, 1);
    chk("first_req", imem_req_valid, 1);
    chk("first_addr", imem_addr, RESET_PC);

    // Sequential fetch, everything always ready
    last_c = -1;
    for (int i = 0; i < 40 && ncons < 4; i++) begin
      c0 = ncons;
      cyc(0, 1, 1, 0, 32'h0, 1);
      if (ncons > c0) begin
        if (last_c >= 0) chk("seq_rate", cyc_n - last_c, 3);
        last_c = cyc_n;
      end
    end
    chk("seq_count", ncons, 4);
    chk("seq_next_addr", imem_addr, 32'h10);

    // Redirect while waiting for the 0x10 response
    cyc(0, 1, 0, 0, 32'h0, 1);
    cyc(0, 1, 0, 1, 32'h200, 1);
    chk("drain_noreq0", imem_req_valid, 0);
    cyc(0, 1, 0, 0, 32'h0, 1);
    chk("drain_noreq1", imem_req_valid, 0);
    cyc(0, 1, 1, 0, 32'h0, 1);
    chk("drain_req", imem_req_valid, 1);
    chk("drain_addr", imem_addr, 32'h200);
    chk("drain_noinstr", instr_valid, 0);

    // Backpressure with 0x13 buffered
    cyc(0, 1, 0, 0, 32'h0, 0);
    cyc(0, 1, 1, 0, 32'h0, 0);
    repeat (5) begin
      chk("bp_valid", instr_valid, 1);
      chk("bp_instr", instr, 32'h13);
      chk("bp_pc", instr_pc, 32'h200);
      chk("bp_noreq", imem_req_valid, 0);
      cyc(0, 1, 1, 0, 32'h0, 0);
    end
    cyc(0, 1, 1, 0, 32'h0, 1);
    chk("bp_next_req", imem_req_valid, 1);
    chk("bp_next_addr", imem_addr, 32'h204);

    // Redirect in the same cycle as the response
    cyc(0, 1, 0, 0, 32'h0, 1);
    cyc(0, 1, 1, 1, 32'h300, 1);
    chk("rsp_redir_req", imem_req_valid, 1);
    chk("rsp_redir_addr", imem_addr, 32'h300);
    chk("rsp_redir_noinstr", instr_valid, 0);

    // Redirect in OUT with a same-cycle consume
    cyc(0, 1, 0, 0, 32'h0, 1);
    cyc(0, 1, 1, 0, 32'h0, 0);
    chk("out_valid", instr_valid, 1);
    c0 = ncons;
    cyc(0, 1, 0, 1, 32'h400, 1);
    chk("out_consumed", ncons, c0 + 1);
    chk("out_redir_noinstr", instr_valid, 0);
    chk("out_redir_req", imem_req_valid, 1);
    chk("out_redir_addr", imem_addr, 32'h400);

    // PC wrap past 0xFFFF_FFFC
    cyc(0, 0, 0, 1, 32'hFFFF_FFFC, 1);
    chk("wrap_start", imem_addr, 32'hFFFF_FFFC);
    c0 = ncons;
    for (int i = 0; i < 20 && ncons < c0 + 2; i++) cyc(0, 1, 1, 0, 32'h0, 1);
    chk("wrap_count", ncons, c0 + 2);
    chk("wrap_addr", imem_addr, 32'h4);

    // Misaligned redirect to 0x102 from REQ
    cyc(0, 0, 0, 1, 32'h102, 1);
`ifdef FETCH_MISALIGN_CHECK_EN
    repeat (5) begin
      chk("mis_fault", misalign_fault, 1);
      chk("mis_noreq", imem_req_valid, 0);
      chk("mis_pc", imem_addr, 32'h102);
      cyc(0, 1, 1, 0, 32'h0, 1);
    end
`else
    chk("mis_req", imem_req_valid, 1);
    chk("mis_addr", imem_addr, 32'h100);
    chk("mis_nofault", misalign_fault, 0);
`endif
    cyc(1, 1, 1, 0, 32'h0, 1);
    cyc(1, 1, 1, 0, 32'h0, 1);
    chk("rerst_fault", misalign_fault, 0);
    chk("rerst_req", imem_req_valid, 0);

    // Random traffic against the scoreboard
    c0 = ncons;
    for (int i = 0; i < 800; i++) begin
      t = $urandom;
`ifdef FETCH_MISALIGN_CHECK_EN
      t[1:0] = 2'b00;
`endif
      if ($urandom_range(0, 7) == 0) t = 32'hFFFF_FFF8;
      cyc(0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
          $urandom_range(0, 11) == 0, t, $urandom_range(0, 3) != 0);
    end
    chk("rand_progress", (ncons - c0) > 30, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the RV32I core. Holds the program counter, issues one word-aligned request at a time to instruction memory, and buffers the returned word for decode. It consumes the redirect decision (taken branch or jump plus target) from the branch/jump logic and squashes any fetch already in flight on the wrong path.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- redirect_valid  in  1  taken branch or jump this cycle
- redirect_target  in  32  new PC when redirect_valid=1
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_addr  out  32  fetch address, equals pc
- imem_rsp_valid  in  1  response data valid
- imem_rsp_data  in  32  instruction word
- instr_valid  out  1  buffered instruction valid for decode
- instr_ready  in  1  decode consumes instruction
- instr  out  32  buffered instruction word
- instr_pc  out  32  address of buffered instruction
- misalign_fault  out  1  sticky misaligned-redirect fault

## Operation
- States: IDLE, REQ, WAIT, OUT, DRAIN, HALT. Reset state is IDLE.
- IDLE: no outputs asserted; always go to REQ.
- REQ: imem_req_valid=1, imem_addr=pc. On imem_req_ready, go to WAIT.
- WAIT: on imem_rsp_valid, capture instr<=imem_rsp_data, instr_pc<=pc, pc<=pc+4 (mod 2^32, wraps 32'hFFFF_FFFC to 0), and go to OUT.
- OUT: instr_valid=1. On instr_ready, go to REQ.
- DRAIN: one wrong-path response is outstanding. On imem_rsp_valid, discard it and go to REQ.
- HALT: no requests, instr_valid=0; only rst exits.
- Redirect has priority over every other event. pc<=redirect_target and the buffer is invalidated. Next state by current state:
  - IDLE, or OUT (with or without instr_ready): go to REQ. A same-cycle instr_ready handshake still counts as consumed.
  - REQ without imem_req_ready: go to REQ. The new address appears next cycle.
  - REQ with imem_req_ready: go to DRAIN.
  - WAIT without imem_rsp_valid: go to DRAIN.
  - WAIT with imem_rsp_valid: discard the response, go to REQ.
  - DRAIN: stay in DRAIN if no response this cycle, else go to REQ.
- At most one request outstanding. imem_rsp_valid outside WAIT/DRAIN is a protocol error; ignore it and flag it with a simulation assertion.
- Reset values: pc=RESET_PC; imem_req_valid=0, instr_valid=0, instr=0, instr_pc=0, misalign_fault=0. rst in any state, including mid-request, returns to IDLE. The bench must not return a response for a request abandoned by reset.

## Timing
- Outputs are registered or decoded from state only. There is no combinational path from any input to any output.
- imem_addr is stable while imem_req_valid=1 and imem_req_ready=0, unless a redirect occurs.
- Earliest response: the cycle after acceptance.
- Best case: req accepted in cycle n, rsp in n+1, instr_valid in n+2, next request in n+3. Throughput is 1 instruction per 3 cycles.
- After rst deasserts: IDLE for 1 cycle, first imem_req_valid on the 2nd cycle.
- Redirect in cycle n: imem_addr=redirect_target in cycle n+1 unless draining.

## Configuration
- FETCH_MISALIGN_CHECK_EN defined:
  - redirect_valid with redirect_target[1:0]!=0 sets misalign_fault=1 (sticky) and goes to HALT.
  - pc<=redirect_target is still loaded, for the trap logic.
  - An outstanding request's response is dropped.
- Not defined:
  - redirect_target[1:0] is ignored; pc<={redirect_target[31:2],2'b00}.
  - misalign_fault is tied to 0. The port is always present.

## Test plan
- Reset: rst=1 for 3 cycles, then release.
  - Required: imem_req_valid=0 while rst=1 and in the following IDLE cycle, then 1 with imem_addr=RESET_PC.
- Sequential fetch: memory always ready, rsp 1 cycle later with word=addr^32'hA5A5_A5A5, decode always ready.
  - Required: instr_pc sequence 0,4,8,12, each with matching instr, one instr_valid per 3 cycles.
- Backpressure: instr_ready=0 for 5 cycles with instr=32'h0000_0013 buffered.
  - Required: instr and instr_pc held, no new request.
  - Then instr_ready=1: request for pc+4 in the next cycle.
- Redirect in WAIT: request for 0x10 accepted, redirect to 0x200 before the response.
  - Required: DRAIN; the 0x10 response never appears on instr; next imem_addr=0x200.
- Redirect same cycle as rsp, and redirect in OUT with instr_ready=1.
  - Required: response discarded; next imem_addr=target; instr_valid=0 the cycle after.
- Misaligned redirect to 0x102:
  - With FETCH_MISALIGN_CHECK_EN: misalign_fault=1 next cycle, stays 1, no further requests until rst.
  - Without it: next imem_addr=0x100, misalign_fault=0.
